// File: rtl/fetch_controller.sv
// Fetch sequencer for the synchronous-read InstructionMemory: owns the fetch PC,
// absorbs the one-cycle ROM latency in a small FIFO and hands words to decode.
module fetch_controller #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  output logic [31:0] imem_addr,
  output logic        imem_rd_en,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        fault
);

  localparam int unsigned PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned CW = $clog2(BUF_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FAULT
  } state_t;

  state_t        state, state_nxt;
  logic [31:0]   fetch_pc;
  logic [31:0]   inflight_pc;
  logic          inflight;
  logic          fault_q;
  logic [31:0]   buf_instr [BUF_DEPTH];
  logic [31:0]   buf_pc    [BUF_DEPTH];
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;

  logic          redirect_ok, redirect_bad, flush;
  logic          pop, push, issue;
  logic [31:0]   occupancy, credit_limit;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (32'(p) == BUF_DEPTH - 1) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    redirect_ok  = 1'b0;
    redirect_bad = 1'b0;
    case (state)
      FAULT: state_nxt = FAULT;
      default: begin
        if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
          redirect_bad = 1'b1;
          state_nxt    = FAULT;
        end else begin
          redirect_ok = redirect_valid;
          state_nxt   = run ? RUN : IDLE;
        end
      end
    endcase

    flush        = redirect_ok | redirect_bad;
    instr_valid  = (count != '0) && (state != FAULT);
    // A pop in the same cycle as a flush never happened as far as decode is concerned.
    pop          = instr_valid & instr_ready & ~flush;
    push         = inflight & ~flush;
    occupancy    = 32'(count) + 32'(inflight);
    credit_limit = BUF_DEPTH + 32'(pop);
    issue        = (state == RUN) && run && !redirect_valid && (occupancy < credit_limit);
  end

  assign imem_rd_en = issue;
  assign imem_addr  = fetch_pc;
  assign instr      = buf_instr[head];
  assign instr_pc   = buf_pc[head];
  assign fault      = fault_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      fault_q     <= 1'b0;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
        buf_instr[i] <= '0;
        buf_pc[i]    <= '0;
      end
    end else begin
      inflight <= issue;
      if (issue) begin
        fetch_pc    <= fetch_pc + 32'd4;
        inflight_pc <= fetch_pc;
      end
      if (redirect_ok) fetch_pc <= redirect_pc;
      if (redirect_bad) fault_q <= 1'b1;

      if (flush) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (push) begin
          buf_instr[tail] <= imem_rdata;
          buf_pc[tail]    <= inflight_pc;
          tail            <= ptr_inc(tail);
        end
        if (pop) head <= ptr_inc(head);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: ROM model, program-order scoreboard, directed and random phases.
module tb_fetch_controller;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int unsigned WINDOW   = 4096;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_rd_en;
  logic [31:0] imem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        fault;

  fetch_controller #(.RESET_PC(RESET_PC), .BUF_DEPTH(2)) dut (
    .clk(clk), .reset(reset), .run(run),
    .imem_addr(imem_addr), .imem_rd_en(imem_rd_en), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc), .fault(fault)
  );

  always #5 clk = ~clk;

  logic [31:0] rom [1024];
  logic [31:0] exp_q [$];
  int checks = 0;
  int errors = 0;
  int accepts = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected delivery order: program order from the restart point onwards.
  task automatic sb_restart(input logic [31:0] pc);
    exp_q.delete();
    for (int unsigned i = 0; i < WINDOW; i++) exp_q.push_back(pc + 32'(4 * i));
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Synchronous ROM: word for a read issued in one cycle is present during the next.
  initial begin
    logic        pend;
    logic [31:0] addr;
    forever begin
      @(negedge clk);
      pend = imem_rd_en;
      addr = imem_addr;
      @(posedge clk);
      #1;
      imem_rdata = pend ? rom[addr[11:2]] : $urandom;
    end
  end

  // Monitor: every accepted instruction must be the next one in program order.
  always @(negedge clk) begin
    if (!reset && !redirect_valid && instr_valid && instr_ready) begin
      accepts++;
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_pc", instr_pc, 32'hFFFF_FFFF);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        chk("sb_instr_pc", instr_pc, e);
        chk("sb_instr", instr, rom[e[11:2]]);
      end
    end
  end

  initial begin
    int base;
    for (int i = 0; i < 1024; i++) rom[i] = $urandom;
    rom[0] = 32'h2008_0005;
    rom[1] = 32'h2009_000C;
    rom[2] = 32'h0109_5020;
    rom[3] = 32'hAC0A_0018;

    sb_restart(RESET_PC);
    repeat (2) cyc();
    smp();
    chk("rst_valid", 32'(instr_valid), 0);
    chk("rst_rd_en", 32'(imem_rd_en), 0);
    chk("rst_addr", imem_addr, RESET_PC);
    chk("rst_instr", instr, 0);
    chk("rst_instr_pc", instr_pc, 0);
    chk("rst_fault", 32'(fault), 0);
    cyc();

    // Start-up latency and back-to-back delivery
    reset = 1'b0; run = 1'b1; instr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      smp();
      chk("start_valid", 32'(instr_valid), (i == 3) ? 32'd1 : 32'd0);
      if (i == 1) begin
        chk("start_rd_en", 32'(imem_rd_en), 1);
        chk("start_addr", imem_addr, RESET_PC);
      end
      if (i == 3) begin
        chk("first_instr", instr, 32'h2008_0005);
        chk("first_pc", instr_pc, RESET_PC);
      end
      cyc();
    end
    for (int i = 0; i < 4; i++) begin
      smp();
      chk("stream_valid", 32'(instr_valid), 1);
      cyc();
    end

    // Back-pressure: buffer fills, reads stop
    instr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      smp();
      if (i == 4) begin
        chk("stall_rd_en", 32'(imem_rd_en), 0);
        chk("stall_valid", 32'(instr_valid), 1);
      end
      cyc();
    end
    instr_ready = 1'b1;
    repeat (4) cyc();

    // Aligned redirect mid-stream
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    sb_restart(32'h40);
    smp();
    chk("redir_no_issue", 32'(imem_rd_en), 0);
    cyc();
    redirect_valid = 1'b0;
    smp();
    chk("redir_n1_valid", 32'(instr_valid), 0);
    chk("redir_n1_rd_en", 32'(imem_rd_en), 1);
    chk("redir_n1_addr", imem_addr, 32'h40);
    cyc();
    smp();
    chk("redir_n2_valid", 32'(instr_valid), 0);
    cyc();
    smp();
    chk("redir_n3_valid", 32'(instr_valid), 1);
    chk("redir_n3_pc", instr_pc, 32'h40);
    cyc();
    repeat (3) cyc();

    // run low: drain, then resume where fetch left off
    run = 1'b0;
    for (int i = 0; i < 4; i++) begin
      smp();
      if (i == 3) begin
        chk("runoff_valid", 32'(instr_valid), 0);
        chk("runoff_rd_en", 32'(imem_rd_en), 0);
      end
      cyc();
    end
    run = 1'b1;
    repeat (6) cyc();

    // Reset while streaming from a non-reset address
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    sb_restart(32'h200);
    cyc();
    redirect_valid = 1'b0;
    repeat (6) cyc();
    reset = 1'b1;
    sb_restart(RESET_PC);
    cyc();
    reset = 1'b0;
    smp();
    chk("midrst_valid", 32'(instr_valid), 0);
    chk("midrst_rd_en", 32'(imem_rd_en), 0);
    chk("midrst_addr", imem_addr, RESET_PC);
    cyc();
    repeat (8) cyc();

    // Misaligned redirect: sticky fault until reset
    redirect_valid = 1'b1; redirect_pc = 32'h42;
    exp_q.delete();
    cyc();
    redirect_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      smp();
      chk("fault_flag", 32'(fault), 1);
      chk("fault_valid", 32'(instr_valid), 0);
      chk("fault_rd_en", 32'(imem_rd_en), 0);
      cyc();
      run = 1'($urandom_range(0, 1));
      instr_ready = 1'($urandom_range(0, 1));
      redirect_valid = 1'($urandom_range(0, 1));
      redirect_pc = {20'h0, 10'($urandom), 2'b00};
    end
    redirect_valid = 1'b0;
    reset = 1'b1;
    sb_restart(RESET_PC);
    cyc();
    reset = 1'b0; run = 1'b1; instr_ready = 1'b1;
    smp();
    chk("fault_cleared", 32'(fault), 0);
    chk("fault_rst_addr", imem_addr, RESET_PC);
    cyc();

    // Randomised traffic
    for (int i = 0; i < 1500; i++) begin
      run = ($urandom_range(0, 9) != 0);
      instr_ready = ($urandom_range(0, 3) != 0);
      redirect_valid = 1'b0;
      reset = 1'b0;
      if ($urandom_range(0, 299) == 0) begin
        reset = 1'b1;
        sb_restart(RESET_PC);
      end else if ($urandom_range(0, 49) == 0) begin
        redirect_valid = 1'b1;
        redirect_pc = {20'h0, 10'($urandom), 2'b00};
        sb_restart(redirect_pc);
      end
      smp();
      if (imem_rd_en) chk("rand_addr_align", 32'(imem_addr[1:0]), 0);
      cyc();
    end

    // Liveness: sustained flow with everything enabled
    reset = 1'b0; redirect_valid = 1'b0; run = 1'b1; instr_ready = 1'b1;
    repeat (4) cyc();
    base = accepts;
    repeat (20) cyc();
    chk("throughput", 32'((accepts - base) >= 19), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
